// File: rtl/nlfsr_gen.sv
// Nonlinear-feedback shift-register generator. The state stream is decimated by
// STRIDE and handed out over a valid/ready port; the all-zero state triggers a reseed.
module nlfsr_gen #(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      TAP_A        = 6,
  parameter int unsigned      TAP_B        = 5,
  parameter int unsigned      STRIDE       = 1,
  parameter int unsigned      SEL_BITS     = 3,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       load,
  input  logic [WIDTH-1:0]           seed,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(1<<SEL_BITS)-1:0]   onehot_out,
  output logic                       lockup,
  output logic [7:0]                 lockup_count
);

  localparam int unsigned OH_W = 1 << SEL_BITS;

  // FILL: no undelivered word; FULL: out_data holds a word awaiting transfer.
  typedef enum logic {FILL, FULL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             lockup_q, lockup_d;
  logic [7:0]       count_q, count_d;

  logic fb;
  logic stall;
  logic xfer;
  logic shift_ok;
  logic [7:0] count_inc;

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    lockup_d = 1'b0;
    count_d  = count_q;

    fb        = r_q[WIDTH-1] ^ (r_q[TAP_A] & r_q[TAP_B]);
    stall     = (state_q == FULL) & ~out_ready;
    xfer      = (state_q == FULL) & out_ready;
    shift_ok  = en & ~stall & ~load;
    count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

    if (load) begin
      // A load always flushes the pending word, even when the consumer is stalled.
      r_d     = (seed == '0) ? SEED_DEFAULT : seed;
      cnt_d   = 8'd0;
      state_d = FILL;
      if (seed == '0) begin
        lockup_d = 1'b1;
        count_d  = count_inc;
      end
    end else begin
      if (xfer) begin
        state_d = FILL;
      end
      if (shift_ok) begin
        if (r_q == '0) begin
          r_d      = SEED_DEFAULT;
          lockup_d = 1'b1;
          count_d  = count_inc;
        end else begin
          r_d = {r_q[WIDTH-2:0], fb};
          if (cnt_q == 8'(STRIDE - 1)) begin
            cnt_d   = 8'd0;
            data_d  = r_d;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      r_q      <= SEED_DEFAULT;
      cnt_q    <= 8'd0;
      data_q   <= '0;
      lockup_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      lockup_q <= lockup_d;
      count_q  <= count_d;
    end
  end

  assign out_data     = data_q;
  assign out_valid    = (state_q == FULL);
  assign lockup       = lockup_q;
  assign lockup_count = count_q;
  assign onehot_out   = OH_W'(1) << r_q[SEL_BITS-1:0];

endmodule

// File: doc/nlfsr_gen.md
# nlfsr_gen

Parametrised nonlinear-feedback shift-register generator, the generalised successor to the fixed 4-bit NLFSR in the RNG datapath. It has configurable register width and AND-tap positions, and an enable/seed-load control. A stride counter decimates the state stream into words delivered over a valid/ready handshake with backpressure. It also detects the all-zero lockup state, reseeds automatically, and counts recoveries. A live one-hot decode of the low state bits replaces the separate demux for downstream selection logic.

## Interface
- WIDTH, 8, state register width; legal 3..32.
- TAP_A, 6, first AND-tap bit index; legal 0..WIDTH-2.
- TAP_B, 5, second AND-tap bit index; legal 0..WIDTH-2, must differ from TAP_A.
- STRIDE, 1, shifts per delivered word; legal 1..255.
- SEL_BITS, 3, low state bits decoded to one-hot; legal 1..min(WIDTH,5).
- SEED_DEFAULT, 1, reset/recovery seed; WIDTH bits, must be nonzero.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run enable; the register shifts only when en=1 and not stalled.
- load  in  1  one-cycle seed-load strobe.
- seed  in  WIDTH  seed sampled when load=1.
- out_data  out  WIDTH  captured state word.
- out_valid  out  1  out_data holds an undelivered word.
- out_ready  in  1  consumer accepts the word.
- onehot_out  out  2**SEL_BITS  one-hot decode of state[SEL_BITS-1:0], combinational from the live register.
- lockup  out  1  one-cycle pulse on a zero-state recovery.
- lockup_count  out  8  saturating count of recoveries.

## Operation
- Feedback: fb = r[WIDTH-1] ^ (r[TAP_A] & r[TAP_B]). Shift: r <= {r[WIDTH-2:0], fb}.
- Stall condition: stall = out_valid & ~out_ready. Shift fires when shift_ok = en & ~stall & ~load.
- Priority, highest first: reset, then load, then shift, then hold.
- Load:
  - r <= (seed==0 ? SEED_DEFAULT : seed).
  - cnt <= 0 and out_valid <= 0; any pending word is flushed.
  - A zero seed also pulses lockup and increments lockup_count.
- Shift with r==0: treat as recovery.
  - r <= SEED_DEFAULT, lockup pulses, lockup_count increments.
  - cnt does not advance and no word is captured.
- Normal shift:
  - If cnt==STRIDE-1: cnt <= 0, out_data <= next r, out_valid <= 1.
  - Otherwise cnt <= cnt+1.
- Handshake:
  - A transfer occurs when out_valid & out_ready.
  - After a transfer, out_valid <= 0 unless a capture happens in the same cycle, in which case it stays 1 with the new data.
  - out_data holds stable while out_valid=1 and out_ready=0.
- FSM, implicit in out_valid and cnt:
  - FILL (out_valid=0) goes to FULL on a capture.
  - FULL goes to FILL on a transfer without a capture.
  - FULL stays FULL on a transfer with a capture, or while stalled.
  - Load moves any state to FILL.
- lockup_count saturates at 255 and never wraps.
- lockup is high for exactly one cycle per recovery event.

## Timing
- Reset values (one cycle after reset is sampled high):
  - r=SEED_DEFAULT, cnt=0.
  - out_data=0, out_valid=0.
  - lockup=0, lockup_count=0.
  - onehot_out = 1<<SEED_DEFAULT[SEL_BITS-1:0].
- Reset asserted mid-stream discards the pending word and the count on the next edge.
- Load-to-state latency: 1 cycle. The first shift from the loaded seed happens on the following enabled cycle.
- Capture latency: the word appears (out_valid=1) on the same edge as the STRIDE-th shift after a load, reset, or previous capture.
- Throughput: with out_ready held at 1 and en=1, one word every STRIDE cycles, with no bubbles.
- onehot_out follows r with zero latency and is never gated by the stall.
- A load during a stall clears out_valid even if out_ready=0. The word is lost by design.

## Test plan
- Period check. WIDTH=4, TAP_A=2, TAP_B=1, STRIDE=1, load seed 4'b0001, en=1, out_ready=1:
  - out_data sequence is 0010, 0100, 1000, 0001, repeating.
  - Period is 4; onehot_out (SEL_BITS=2) tracks the low 2 bits.
- Second orbit. Same configuration, seed 4'b0110:
  - out_data sequence is 1101, 1011, 0111, 1111, 1110, 1100, 1001, 0011, 0110.
  - Period is 9.
- Backpressure. STRIDE=2, seed 0001, out_ready=0 after the first capture:
  - out_valid stays 1 and out_data holds at 0100.
  - r freezes at 0100.
  - After out_ready=1 for one cycle, the next word is 0001 two shifts later.
- Lockup and saturation:
  - load seed 0 with SEED_DEFAULT=4'b0001: r becomes 0001, lockup pulses for one cycle, lockup_count=1.
  - After 300 zero-seed loads, lockup_count=255.
- Simultaneous events:
  - A transfer and a capture in the same cycle keep out_valid=1 with the new word.
  - Load together with en=1 loads the seed and does not shift.
  - Reset together with load yields the reset values.
- Enable gating:
  - With en=0 for 10 cycles, r and cnt are unchanged and no word is captured.
